// File: rtl/imem_arbiter_if.sv
// One requester port of the instruction-memory arbiter: request/grant handshake plus the read response.
// Latency: response one cycle after grant; backpressure: grant is the only throttle, responses cannot stall.
interface imem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction memory read port between fetch and debug requesters.
// Latency: grant 0 cycles, response 1 cycle after grant; backpressure: none on responses, requests wait for gnt.
module imem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_arbiter_if.slave    f_if,
  imem_arbiter_if.slave    d_if,
  output logic             mem_en_o,
  output logic [AW-3:0]    mem_addr_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DEBUG = 1'b1
  } port_e;

  port_e         last_gnt_q, last_gnt_d;
  port_e         rsp_owner_q, rsp_owner_d;
  port_e         gnt_port;
  logic          rsp_v_q, rsp_v_d;
  logic          rsp_err_q, rsp_err_d;
  logic          any_gnt;
  logic          aligned;
  logic [AW-1:0] sel_addr;
  logic          f_rvalid, d_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= PORT_DEBUG;
      rsp_owner_q <= PORT_FETCH;
      rsp_v_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_v_q     <= rsp_v_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Grants are gated by rst_n so nothing leaks to the memory while reset is held.
  always_comb begin
    gnt_port = PORT_FETCH;
    any_gnt  = 1'b0;
    if (rst_n) begin
      any_gnt = f_if.req | d_if.req;
      if (f_if.req && d_if.req) begin
        gnt_port = (last_gnt_q == PORT_FETCH) ? PORT_DEBUG : PORT_FETCH;
      end else if (d_if.req) begin
        gnt_port = PORT_DEBUG;
      end
    end

    sel_addr   = (gnt_port == PORT_DEBUG) ? d_if.addr : f_if.addr;
    aligned    = (sel_addr[1:0] == 2'b00);
    mem_en_o   = any_gnt && aligned;
    mem_addr_o = mem_en_o ? sel_addr[AW-1:2] : '0;

    last_gnt_d  = any_gnt ? gnt_port : last_gnt_q;
    rsp_v_d     = any_gnt;
    rsp_owner_d = any_gnt ? gnt_port : rsp_owner_q;
    rsp_err_d   = any_gnt ? !aligned : rsp_err_q;
  end

  assign f_if.gnt = any_gnt && (gnt_port == PORT_FETCH);
  assign d_if.gnt = any_gnt && (gnt_port == PORT_DEBUG);

  assign f_rvalid = rsp_v_q && (rsp_owner_q == PORT_FETCH);
  assign d_rvalid = rsp_v_q && (rsp_owner_q == PORT_DEBUG);

  // Misaligned responses return zero data regardless of what the memory bus carries.
  assign f_if.rvalid = f_rvalid;
  assign f_if.err    = f_rvalid && rsp_err_q;
  assign f_if.rdata  = (f_rvalid && !rsp_err_q) ? mem_rdata_i : '0;

  assign d_if.rvalid = d_rvalid;
  assign d_if.err    = d_rvalid && rsp_err_q;
  assign d_if.rdata  = (d_rvalid && !rsp_err_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: driver predicts grants/responses, a negedge monitor pops and compares.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(32), .DW(32)) f_if ();
  imem_arbiter_if #(.AW(32), .DW(32)) d_if ();

  logic        mem_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;

  imem_arbiter #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_if       (f_if),
    .d_if       (d_if),
    .mem_en_o   (mem_en),
    .mem_addr_o (mem_addr),
    .mem_rdata_i(mem_rdata)
  );

  // Memory: one-cycle read latency; garbage on the bus when not enabled.
  logic [31:0] mem [256];
  always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr[7:0]] : $urandom;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        fg;
    logic        dg;
    logic        men;
    logic [29:0] maddr;
  } gnt_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  gnt_t  gq[$];
  rsp_t  rq[2][$];
  string pn[2] = '{"f", "d"};

  int n_chk  = 0;
  int n_pass = 0;

  logic        f_pend, d_pend;
  logic [31:0] f_pa, d_pa;
  logic        model_last;  // 0: fetch won last, 1: debug won last

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: each requester holds one pending request; the winner is
  // the sole requester, or on contention whichever did not win last time.
  task automatic drive_cycle();
    int          win;
    logic [31:0] a;
    gnt_t        g;
    rsp_t        r;
    f_if.req  = f_pend;
    f_if.addr = f_pend ? f_pa : $urandom;
    d_if.req  = d_pend;
    d_if.addr = d_pend ? d_pa : $urandom;
    if (f_pend && d_pend) win = model_last ? 0 : 1;
    else if (f_pend)      win = 0;
    else if (d_pend)      win = 1;
    else                  win = -1;
    g.cyc = cyc; g.fg = (win == 0); g.dg = (win == 1); g.men = 1'b0; g.maddr = '0;
    if (win >= 0) begin
      a      = (win == 0) ? f_pa : d_pa;
      r.due  = cyc + 1;
      r.err  = (a[1:0] != 2'b00);
      r.data = r.err ? 32'd0 : mem[a[9:2]];
      if (!r.err) begin
        g.men   = 1'b1;
        g.maddr = a[31:2];
      end
      rq[win].push_back(r);
      model_last = (win == 1);
      if (win == 0) f_pend = 1'b0;
      else          d_pend = 1'b0;
    end
    gq.push_back(g);
    @(posedge clk); #1;
  endtask

  // Reset drops anything in flight; requests are held high to show grants stay gated.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    rq[0].delete();
    rq[1].delete();
    gq.delete();
    model_last = 1'b1;
    f_pend = 1'b0;
    d_pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      f_if.req = 1'b1; f_if.addr = 32'h40;
      d_if.req = 1'b1; d_if.addr = 32'h80;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  gnt_t        mg;
  rsp_t        mr;
  logic        m_rv, m_er, due_now;
  logic [31:0] m_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {57'd0, f_if.gnt, d_if.gnt, f_if.rvalid, d_if.rvalid,
                         f_if.err, d_if.err, mem_en}, 64'd0);
      chk("reset_mem_addr", {34'd0, mem_addr}, 64'd0);
      chk("reset_rdata", {f_if.rdata, d_if.rdata}, 64'd0);
    end else begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        mg = gq.pop_front();
        chk("f_gnt", f_if.gnt, mg.fg);
        chk("d_gnt", d_if.gnt, mg.dg);
        chk("mem_en", mem_en, mg.men);
        chk("mem_addr", mem_addr, mg.maddr);
      end
      for (int p = 0; p < 2; p++) begin
        m_rv = (p == 0) ? f_if.rvalid : d_if.rvalid;
        m_rd = (p == 0) ? f_if.rdata  : d_if.rdata;
        m_er = (p == 0) ? f_if.err    : d_if.err;
        due_now = (rq[p].size() > 0) && (rq[p][0].due == cyc);
        chk($sformatf("%s_rvalid", pn[p]), m_rv, due_now);
        if (due_now) begin
          mr = rq[p].pop_front();
          chk($sformatf("%s_rdata", pn[p]), m_rd, mr.data);
          chk($sformatf("%s_err", pn[p]), m_er, mr.err);
        end else begin
          chk($sformatf("%s_idle_quiet", pn[p]), {m_er, m_rd}, 64'd0);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    f_pend = 1'b0; d_pend = 1'b0;
    f_pa   = '0;   d_pa   = '0;
    model_last = 1'b1;
    f_if.req = 1'b0; f_if.addr = '0;
    d_if.req = 1'b0; d_if.addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    @(posedge clk); #1;
    do_reset(3);

    // Fetch-only stream.
    for (int i = 0; i < 3; i++) begin
      f_pend = 1'b1; f_pa = 32'(4 * i);
      drive_cycle();
    end
    drive_cycle();

    // Continuous contention from reset: F, D, F, D.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      if (!f_pend) begin f_pend = 1'b1; f_pa = 32'h10; end
      if (!d_pend) begin d_pend = 1'b1; d_pa = 32'h20; end
      drive_cycle();
    end
    f_pend = 1'b0; d_pend = 1'b0;
    drive_cycle();

    // Misaligned debug access, then contention.
    d_pend = 1'b1; d_pa = 32'h6;
    drive_cycle();
    f_pend = 1'b1; f_pa = 32'h0;
    d_pend = 1'b1; d_pa = 32'h8;
    drive_cycle();
    drive_cycle();
    drive_cycle();

    // Reset the cycle after a grant; the in-flight response must vanish.
    f_pend = 1'b1; f_pa = 32'h4;
    drive_cycle();
    do_reset(2);
    f_pend = 1'b1; f_pa = 32'h8;
    d_pend = 1'b1; d_pa = 32'hC;
    drive_cycle();
    drive_cycle();
    drive_cycle();

    // Idle gap: last winner must be remembered across idle cycles.
    f_pend = 1'b1; f_pa = 32'h14;
    drive_cycle();
    for (int i = 0; i < 3; i++) drive_cycle();
    f_pend = 1'b1; f_pa = 32'h18;
    d_pend = 1'b1; d_pa = 32'h1C;
    drive_cycle();
    drive_cycle();
    drive_cycle();

    // Single debug request inside a continuous fetch stream.
    for (int i = 0; i < 8; i++) begin
      if (!f_pend) begin f_pend = 1'b1; f_pa = 32'h100 + 32'(4 * i); end
      if (i == 2) begin d_pend = 1'b1; d_pa = 32'h200; end
      drive_cycle();
    end
    f_pend = 1'b0;
    drive_cycle();
    drive_cycle();

    // Randomized traffic with occasional misaligned addresses.
    for (int i = 0; i < 400; i++) begin
      if (!f_pend && $urandom_range(0, 9) < 6) begin f_pend = 1'b1; f_pa = rand_addr(); end
      if (!d_pend && $urandom_range(0, 9) < 6) begin d_pend = 1'b1; d_pa = rand_addr(); end
      drive_cycle();
    end
    f_pend = 1'b0; d_pend = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single-ported instruction memory between the core fetch stage and the debug/loader port. It grants at most one word read per cycle using round-robin on contention. It drives the memory with a word address and routes the one-cycle-latency read data back to the requester that issued it. It sits between the fetch stage and the instruction memory and is the only master of the memory's read port.

## Interface
- `AW`, 32, byte-address width of both requester ports.
- `DW`, 32, instruction/data word width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  AW  fetch byte address.
- `f_gnt`  out  1  fetch request accepted this cycle (combinational).
- `f_rvalid`  out  1  fetch response valid.
- `f_rdata`  out  DW  fetch response word.
- `f_err`  out  1  fetch response is a misalignment error; qualified by `f_rvalid`.
- `d_req`, `d_addr`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: debug port, same widths and meaning as the fetch port.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  AW-2  word address, equal to the granted byte address [AW-1:2].
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en`.

## Operation
- Request rules:
  - A requester holds `req` high with a stable `addr` until it sees `gnt`.
  - `gnt` is a one-cycle pulse; the request is consumed on that edge.
  - Back-to-back requests are allowed: `req` may stay high after `gnt` to issue the next address.
- Arbitration:
  - Only one port requests: that port is granted the same cycle.
  - Both ports request: the port not recorded in `last_gnt` is granted.
  - `last_gnt` (1 bit, FETCH/DEBUG) updates on every grant.
  - Neither port requests: no grant, `mem_en` = 0, `last_gnt` holds.
- Aligned grant (`addr[1:0]` == 0): `mem_en` = 1 and `mem_addr` = `addr[AW-1:2]` in the grant cycle.
- Misaligned grant (`addr[1:0]` != 0):
  - The grant is still issued and still updates `last_gnt`.
  - `mem_en` stays 0.
  - The response carries `err` = 1 and `rdata` = 0.
- Response tracking registers:
  - `rsp_v`: a response is due.
  - `rsp_owner`: which port gets it.
  - `rsp_err`: the response is an error.
  - All three are loaded on every grant edge.
  - `rsp_v` clears on any cycle with no grant.
- Response outputs:
  - `X_rvalid` = `rsp_v` && `rsp_owner` == X.
  - `X_rdata` = `mem_rdata` when `X_rvalid` && !`rsp_err`, else 0.
  - `X_err` = `X_rvalid` && `rsp_err`.
  - The non-owning port sees `rvalid`, `rdata` and `err` all 0.
- Responses cannot be back-pressured; requesters must always accept them.
- Reset (asynchronous, any time):
  - `rsp_v`, `rsp_owner` and `rsp_err` clear to 0.
  - `last_gnt` resets to DEBUG, so fetch wins the first contention.
  - A response in flight is dropped and never presented.
  - While `rst_n` = 0: every `gnt`, `rvalid` and `err` is 0, `mem_en` = 0, `mem_addr` = 0, all `rdata` = 0.

## Timing
- Grant latency: 0 cycles (combinational from `req`/`addr`/`last_gnt`).
- Read latency: response exactly 1 cycle after the grant cycle.
- Throughput: 1 grant per cycle across both ports.
  - Under continuous contention the ports alternate F, D, F, D…
  - Each port then sees 1 grant every 2 cycles.
- A grant and the previous grant's response may occur in the same cycle, to the same or different ports.
- `mem_en`/`mem_addr` are combinational. `mem_addr` = 0 whenever there is no aligned grant.

## Test plan
- Fetch-only stream, `f_addr` = 0x0, 0x4, 0x8, memory holds 0x11,0x22,0x33 -> `f_gnt` each cycle, `mem_addr` 0,1,2, `f_rdata` 0x11,0x22,0x33 one cycle later, `d_*` all 0.
- Simultaneous `f_req`/`d_req` from reset, `f_addr` = 0x10, `d_addr` = 0x20 held -> grants F, D, F, D; `mem_addr` 4, 8, 4, 8; responses routed to the matching port each following cycle.
- Misaligned `d_addr` = 0x6 -> `d_gnt` = 1, `mem_en` = 0; next cycle `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0; following contention grants fetch.
- Reset asserted the cycle after a grant -> no `rvalid` on either port, all outputs 0 during reset; after release, first contention grants fetch.
- Idle gap: fetch request, 3 idle cycles, debug request -> exactly one `rvalid` per grant, `mem_en` 0 in idle cycles, `last_gnt` held across the gap.
- Debug single request during continuous fetch stream -> debug granted within 2 cycles, fetch resumes the next cycle, no response lost or duplicated.
